// File: rtl/mult_serial_param.sv
// Parametrised shift-add multiplier: N x N -> 2N product, D multiplier bits per cycle,
// with start/busy/done handshake and per-operation signed/unsigned mode.
module mult_serial_param #(
    parameter int N = 16,
    parameter int D = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           tc,
    input  logic [N-1:0]   g_input,
    input  logic [N-1:0]   e_input,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] o
);

    localparam int W  = 2 * N;
    localparam int S  = N / D;
    localparam int CW = $clog2(S + 1);

    generate
        if (N < 2 || D < 1 || (N % D) != 0) begin : g_bad_params
            $error("mult_serial_param: need N >= 2, D >= 1 and N divisible by D");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    g_q, g_d;
    logic [N-1:0]    e_q, e_d;
    logic            tc_q, tc_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [W-1:0]    o_q, o_d;

    logic [W-1:0]    digit_s;
    logic            neg_s;
    logic [W-1:0]    corr_s;
    logic [W-1:0]    pp_s;
    logic [W-1:0]    sum_s;

    // Multiplicand widened to the product width, sign-extended only in signed mode.
    function automatic logic [W-1:0] extend(input logic [N-1:0] v, input logic s);
        return {{N{s & v[N-1]}}, v};
    endfunction

    // Partial product for the current digit; g_q is kept pre-shifted to the digit weight.
    always_comb begin
        digit_s = {{(W-D){1'b0}}, e_q[D-1:0]};
        // On the last step the top multiplier bit weighs -2^(N-1) in signed mode.
        neg_s   = tc_q & (cnt_q == CW'(1)) & e_q[D-1];
        corr_s  = neg_s ? (g_q << D) : {W{1'b0}};
        pp_s    = (g_q * digit_s) - corr_s;
        sum_s   = acc_q + pp_s;
    end

    // Next-state logic for the handshake FSM and datapath registers.
    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        e_d     = e_q;
        tc_d    = tc_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        o_d     = o_q;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    g_d     = extend(g_input, tc);
                    e_d     = e_input;
                    tc_d    = tc;
                    acc_d   = {W{1'b0}};
                    cnt_d   = CW'(S);
                    busy_d  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d = sum_s;
                g_d   = g_q << D;
                e_d   = e_q >> D;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    o_d     = sum_s;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                    // A start on the completing edge chains the next product with no gap.
                    if (start) begin
                        g_d     = extend(g_input, tc);
                        e_d     = e_input;
                        tc_d    = tc;
                        acc_d   = {W{1'b0}};
                        cnt_d   = CW'(S);
                        busy_d  = 1'b1;
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            g_q     <= {W{1'b0}};
            e_q     <= {N{1'b0}};
            tc_q    <= 1'b0;
            acc_q   <= {W{1'b0}};
            cnt_q   <= {CW{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            o_q     <= {W{1'b0}};
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            e_q     <= e_d;
            tc_q    <= tc_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            o_q     <= o_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign o    = o_q;

endmodule

// File: tb/tb_mult_serial_param.sv
// Randomized self-checking bench for mult_serial_param: one instance with D=1, one with D=4.
module tb_mult_serial_param;

    logic        clk;
    logic        rst;
    logic        start_s [2];
    logic        tc_s    [2];
    logic [15:0] g_s     [2];
    logic [15:0] e_s     [2];
    logic        busy_s  [2];
    logic        done_s  [2];
    logic [31:0] o_s     [2];

    int n_tests = 0;
    int n_fail  = 0;

    mult_serial_param #(.N(16), .D(1)) u_d1 (
        .clk(clk), .rst(rst), .start(start_s[0]), .tc(tc_s[0]),
        .g_input(g_s[0]), .e_input(e_s[0]),
        .busy(busy_s[0]), .done(done_s[0]), .o(o_s[0])
    );

    mult_serial_param #(.N(16), .D(4)) u_d4 (
        .clk(clk), .rst(rst), .start(start_s[1]), .tc(tc_s[1]),
        .g_input(g_s[1]), .e_input(e_s[1]),
        .busy(busy_s[1]), .done(done_s[1]), .o(o_s[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer product, signed or unsigned, reduced to 32 bits.
    function automatic logic [31:0] model(input logic [15:0] g, input logic [15:0] e, input logic tc);
        longint a, b, p;
        if (tc) begin
            a = longint'($signed(g));
            b = longint'($signed(e));
        end else begin
            a = longint'(g);
            b = longint'(e);
        end
        p = a * b;
        return p[31:0];
    endfunction

    // One complete operation on instance idx with latency, busy and pulse-width checks.
    task automatic run_op(input int idx, input logic [15:0] g, input logic [15:0] e,
                          input logic tc, input string tag);
        int steps;
        int lat;
        int bc;
        logic [31:0] exp;
        steps = (idx == 0) ? 16 : 4;
        exp   = model(g, e, tc);
        lat   = -1;
        bc    = 0;
        @(negedge clk);
        start_s[idx] = 1'b1;
        g_s[idx]     = g;
        e_s[idx]     = e;
        tc_s[idx]    = tc;
        @(posedge clk);
        #1;
        start_s[idx] = 1'b0;
        if (busy_s[idx]) bc++;
        for (int k = 1; k <= steps + 4; k++) begin
            @(posedge clk);
            #1;
            if (busy_s[idx]) bc++;
            if (done_s[idx]) begin
                lat = k;
                break;
            end
        end
        check({tag, "_latency"}, 64'(lat), 64'(steps));
        check({tag, "_o"}, 64'(o_s[idx]), 64'(exp));
        check({tag, "_busy_cycles"}, 64'(bc), 64'(steps));
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 64'(done_s[idx]), 64'd0);
        check({tag, "_o_hold"}, 64'(o_s[idx]), 64'(exp));
    endtask

    initial begin
        int nd;
        int at0;
        int at1;
        logic [31:0] o0;
        logic [31:0] o1;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0;
            tc_s[i]    = 1'b0;
            g_s[i]     = 16'd0;
            e_s[i]     = 16'd0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("reset_busy", 64'(busy_s[i]), 64'd0);
            check("reset_done", 64'(done_s[i]), 64'd0);
            check("reset_o", 64'(o_s[i]), 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        run_op(0, 16'd3, 16'd5, 1'b0, "d1_u_3x5");
        run_op(0, 16'hFFFD, 16'd5, 1'b1, "d1_s_m3x5");
        run_op(0, 16'h8000, 16'h8000, 1'b1, "d1_s_min");
        run_op(1, 16'hFFFF, 16'hFFFF, 1'b0, "d4_u_max");
        run_op(1, 16'hFFFF, 16'hFFFF, 1'b1, "d4_s_m1");
        run_op(1, 16'h8000, 16'h7FFF, 1'b1, "d4_s_mix");

        // Start pulsed while busy must be ignored.
        nd  = 0;
        at0 = -1;
        @(negedge clk);
        start_s[0] = 1'b1; g_s[0] = 16'd3; e_s[0] = 16'd5; tc_s[0] = 1'b0;
        @(posedge clk);
        #1;
        start_s[0] = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            if (k == 5) begin
                start_s[0] = 1'b1; g_s[0] = 16'd7; e_s[0] = 16'd7;
            end
            @(posedge clk);
            #1;
            start_s[0] = 1'b0;
            if (done_s[0]) begin
                nd++;
                if (at0 < 0) begin
                    at0 = k;
                    o0  = o_s[0];
                end
            end
        end
        check("busy_ign_count", 64'(nd), 64'd1);
        check("busy_ign_cycle", 64'(at0), 64'd16);
        check("busy_ign_o", 64'(o0), 64'h0000000F);

        // Back-to-back with start held high.
        nd  = 0;
        at0 = -1;
        at1 = -1;
        @(negedge clk);
        start_s[0] = 1'b1; g_s[0] = 16'd2; e_s[0] = 16'd3; tc_s[0] = 1'b0;
        @(posedge clk);
        #1;
        g_s[0] = 16'd4; e_s[0] = 16'd5;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done_s[0]) begin
                nd++;
                if (nd == 1) begin
                    at0 = k; o0 = o_s[0];
                    start_s[0] = 1'b0;
                end else if (nd == 2) begin
                    at1 = k; o1 = o_s[0];
                end
            end
        end
        check("b2b_count", 64'(nd), 64'd2);
        check("b2b_first_cycle", 64'(at0), 64'd16);
        check("b2b_first_o", 64'(o0), 64'd6);
        check("b2b_second_cycle", 64'(at1), 64'd32);
        check("b2b_second_o", 64'(o1), 64'd20);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        start_s[0] = 1'b1; g_s[0] = 16'd3; e_s[0] = 16'd5; tc_s[0] = 1'b0;
        @(posedge clk);
        #1;
        start_s[0] = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid_o", 64'(o_s[0]), 64'd0);
        check("rst_mid_busy", 64'(busy_s[0]), 64'd0);
        check("rst_mid_done", 64'(done_s[0]), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        nd = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (done_s[0]) nd++;
        end
        check("rst_no_done", 64'(nd), 64'd0);
        check("rst_o_still0", 64'(o_s[0]), 64'd0);
        run_op(0, 16'd2, 16'd2, 1'b0, "after_rst_2x2");

        // Randomized operands and modes on both instances.
        for (int i = 0; i < 40; i++) begin
            int          sel;
            logic [15:0] rg;
            logic [15:0] re;
            logic        rtc;
            sel = int'($urandom_range(0, 1));
            rg  = 16'($urandom);
            re  = 16'($urandom);
            rtc = 1'($urandom_range(0, 1));
            if (i % 10 == 0) rg = 16'h8000;
            if (i % 10 == 1) re = 16'h8000;
            run_op(sel, rg, re, rtc, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
